// File: rtl/logic_arbiter_if.sv
// Request/operand/result bundle between two requesters and logic_arbiter.
// master = requester side, slave = arbiter side.
interface logic_arbiter_if;
  logic        req0;
  logic [1:0]  op0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        req1;
  logic [1:0]  op1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] res;
  logic        done;
  logic        done_id;
  logic        busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, res, done, done_id, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, res, done, done_id, busy
  );
endinterface

// File: rtl/logic_arbiter.sv
// Two-requester arbiter feeding a one-shot 32-bit bitwise logic unit (IDLE -> EXEC -> DONE).
// Define LOGIC_ARBITER_RR_EN for round-robin ties; otherwise requester 0 has fixed priority.
module logic_arbiter (
  input  logic           clk,
  input  logic           rst,
  logic_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  logic [1:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] res_r;
  logic        gnt0_r;
  logic        gnt1_r;
  logic        done_r;
  logic        done_id_r;
  logic        busy_r;
  logic        last_id_r;

  logic        any_req_s;
  logic        winner_s;
  logic [1:0]  win_op_s;
  logic [31:0] win_a_s;
  logic [31:0] win_b_s;

  function automatic logic [31:0] logic_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      2'b00:   logic_op = a & b;
      2'b01:   logic_op = a | b;
      2'b10:   logic_op = ~(a | b);
      2'b11:   logic_op = a ^ b;
      default: logic_op = 32'h0000_0000;
    endcase
  endfunction

  // Winner selection and operand mux for the IDLE grant edge
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    winner_s  = 1'b0;
`ifdef LOGIC_ARBITER_RR_EN
    if (bus.req0 && bus.req1) begin
      winner_s = ~last_id_r;
    end else if (bus.req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
`else
    if (bus.req0) begin
      winner_s = 1'b0;
    end else if (bus.req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
`endif
    win_op_s = bus.op0;
    win_a_s  = bus.a0;
    win_b_s  = bus.b0;
    if (winner_s) begin
      win_op_s = bus.op1;
      win_a_s  = bus.a1;
      win_b_s  = bus.b1;
    end else begin
      win_op_s = bus.op0;
      win_a_s  = bus.a0;
      win_b_s  = bus.b0;
    end
  end

  // Control FSM with registered pulses, result and ownership
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 2'b00;
      a_r       <= 32'h0000_0000;
      b_r       <= 32'h0000_0000;
      res_r     <= 32'h0000_0000;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      busy_r    <= 1'b0;
      last_id_r <= 1'b1;
    end else begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r   <= EXEC;
            gnt0_r    <= ~winner_s;
            gnt1_r    <= winner_s;
            last_id_r <= winner_s;
            op_r      <= win_op_s;
            a_r       <= win_a_s;
            b_r       <= win_b_s;
            busy_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        EXEC: begin
          state_r   <= DONE;
          res_r     <= logic_op(op_r, a_r, b_r);
          done_r    <= 1'b1;
          done_id_r <= last_id_r;
          busy_r    <= 1'b1;
        end
        DONE: begin
          // requests are ignored here; a held request is taken in the following IDLE cycle
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_r;
  assign bus.gnt1    = gnt1_r;
  assign bus.res     = res_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: vector table plus scoreboard queue, with
// hand sequences for ties, reset mid-operation and idle behaviour.
module tb_logic_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_arbiter_if bus ();

  logic_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } exp_t;

  vec_t vecs [9];
  exp_t sb_q [$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    if (id) begin
      bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end else begin
      bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end
  endtask

  task automatic wait_gnt(output logic got, output logic id, output int cyc);
    got = 1'b0; id = 1'b0; cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.gnt0 || bus.gnt1) begin
        got = 1'b1;
        id  = bus.gnt1;
        check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'h0);
        check("busy_in_exec", 32'(bus.busy), 32'h1);
        break;
      end
    end
    check("gnt_seen", 32'(got), 32'h1);
  endtask

  task automatic wait_done(output logic got, output int cyc);
    got = 1'b0; cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'h1);
  endtask

  // pops the oldest expectation and compares it with the completed result
  task automatic score_done(output logic [31:0] exp_res);
    exp_t e;
    exp_res = 32'h0;
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_empty: got done with res %h expected no completion", bus.res);
    end else begin
      e = sb_q.pop_front();
      exp_res = e.res;
      check("res", bus.res, e.res);
      check("done_id", 32'(bus.done_id), 32'(e.id));
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic got; logic gid; int cyc; logic [31:0] er;
    exp_t e;
    @(negedge clk);
    drive_req(v.id, v.op, v.a, v.b);
    e.id = v.id; e.res = v.exp_res;
    sb_q.push_back(e);
    wait_gnt(got, gid, cyc);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    if (!got) begin
      void'(sb_q.pop_front());
      return;
    end
    check("gnt_latency", 32'(cyc), 32'd1);
    check("gnt_id", 32'(gid), 32'(v.id));
    // operands change right after capture and must not affect the result
    if (v.id) begin
      bus.a1 = $urandom; bus.b1 = $urandom; bus.op1 = 2'($urandom_range(3, 0));
    end else begin
      bus.a0 = $urandom; bus.b0 = $urandom; bus.op0 = 2'($urandom_range(3, 0));
    end
    wait_done(got, cyc);
    if (!got) begin
      void'(sb_q.pop_front());
      return;
    end
    check("done_latency", 32'(cyc), 32'd1);
    score_done(er);
    @(posedge clk); #1;
    check("res_hold", bus.res, er);
    check("done_pulse_end", 32'(bus.done), 32'h0);
    check("busy_end", 32'(bus.busy), 32'h0);
  endtask

  logic [3:0] tie_order;
  logic       got;
  logic       gid;
  int         cyc;
  logic [31:0] er;
  int         seen_done;
  exp_t       te;

  initial begin
    vecs[0] = '{1'b0, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{1'b1, 2'b11, 32'h0000_000F, 32'h0000_0005, 32'h0000_000A};
    vecs[3] = '{1'b0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[4] = '{1'b0, 2'b01, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[5] = '{1'b1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};
    vecs[6] = '{1'b1, 2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 2'b11, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h2152_4110};
    vecs[8] = '{1'b0, 2'b10, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F};
`ifdef LOGIC_ARBITER_RR_EN
    tie_order = 4'b1010;  // bit k = winner of tie k: 0,1,0,1
`else
    tie_order = 4'b0000;
`endif

    bus.req0 = 1'b0; bus.op0 = 2'b00; bus.a0 = 32'h0; bus.b0 = 32'h0;
    bus.req1 = 1'b0; bus.op1 = 2'b00; bus.a1 = 32'h0; bus.b1 = 32'h0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_pulses", {28'h0, bus.gnt0, bus.gnt1, bus.done, bus.busy}, 32'h0);
    check("rst_res", bus.res, 32'h0);
    check("rst_done_id", 32'(bus.done_id), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_quiet", {28'h0, bus.gnt0, bus.gnt1, bus.done, bus.busy}, 32'h0);
    end

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // tie: both requests held from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b0, 2'b00, 32'hFFFF_0000, 32'h0FF0_0FF0);
    drive_req(1'b1, 2'b11, 32'h0000_0001, 32'h0000_0003);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(got, gid, cyc);
      if (!got) break;
      check("tie_gnt_gap", 32'(cyc), (k == 0) ? 32'd1 : 32'd2);
      check("tie_order", 32'(gid), 32'(tie_order[k]));
      te.id  = tie_order[k];
      te.res = tie_order[k] ? 32'h0000_0002 : 32'h0FF0_0000;
      sb_q.push_back(te);
      wait_done(got, cyc);
      if (!got) begin
        void'(sb_q.pop_front());
        break;
      end
      score_done(er);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("tie_idle", 32'(bus.busy), 32'h0);

    // reset asserted during EXEC discards the operation
    @(negedge clk);
    drive_req(1'b0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_gnt(got, gid, cyc);
    rst = 1'b1;
    #1;
    check("midrst_pulses", {28'h0, bus.gnt0, bus.gnt1, bus.done, bus.busy}, 32'h0);
    check("midrst_res", bus.res, 32'h0);
    check("midrst_done_id", 32'(bus.done_id), 32'h0);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    check("no_done_after_rst", 32'(seen_done), 32'h0);
    run_vec(vecs[3]);
    run_vec(vecs[2]);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
